clock_divider_multi: RTL
========================

# clock_divider_multi

Parametrised, runtime-programmable multi-channel clock divider. It generates NUM_CH independent divided outputs from the single system clock. Each channel runs in square-wave mode (divided clock) or pulse mode (one-cycle strobe). Divisor and mode are written through a shadowed register port, and updates take effect glitch-free at the channel's next period boundary. It sits between the system clock and the game-timing consumers: block scroll rate, note tempo and display refresh strobes.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- WIDTH, 32: divisor/counter width in bits.
- DEFAULT_DIV, 1: reset value of every channel's active divisor.
- CH_W, 2: width of wr_ch; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  global phase restart (only functional with CLKDIV_SYNC_EN).
- wr_en  in  1  write strobe for divisor/mode.
- wr_ch  in  CH_W  target channel; values >= NUM_CH are ignored.
- wr_div  in  WIDTH  new divisor value D.
- wr_mode  in  1  0 = square, 1 = pulse.
- clk_out  out  NUM_CH  registered divided output per channel.
- pend  out  NUM_CH  1 = channel holds an unapplied write.

## Operation
Per-channel state:
- cnt[WIDTH], div_act[WIDTH], mode_act, div_pend[WIDTH], mode_pend, pend.

Enabled channel, each cycle:
- If cnt == div_act (wrap):
  - cnt <= 0.
  - Square mode: clk_out toggles.
  - Pulse mode: clk_out <= 1.
  - If pend: div_act <= div_pend, mode_act <= mode_pend, pend <= 0.
- Otherwise:
  - cnt <= cnt + 1.
  - Pulse mode: clk_out <= 0.

Resulting periods:
- Square mode: half-period = D+1 cycles; full period = 2(D+1).
- Pulse mode: one-cycle high pulse every D+1 cycles.
- D = 0: square toggles every cycle; pulse output stays high.

Disabled channel (en = 0):
- cnt <= 0 and clk_out <= 0.
- A write to a disabled channel loads div_act/mode_act directly on the next edge; pend stays 0.

Writes to an enabled channel:
- Land in div_pend/mode_pend and set pend.
- A second write before the wrap overwrites the pending value. Last write wins.
- Writes with wr_ch >= NUM_CH: no effect.

Mode change at a wrap:
- clk_out is forced to 0 at that wrap edge, so the new mode starts from a low level.

Priority per channel: rst > sync (if compiled) > en = 0 > wrap > count.

Arithmetic:
- cnt compares for equality only. cnt never exceeds div_act, so there is no overflow.
- A divisor of 2**WIDTH-1 is legal.

## Timing
Reset values:
- clk_out = 0, pend = 0, cnt = 0, div_act = DEFAULT_DIV, mode_act = square, pending registers = 0.
- Reset overrides a same-cycle write.

Enable behaviour:
- First clk_out change occurs on the edge ending the (D+1)th consecutive cycle with en = 1.
- Dropping en mid-period discards the partial count.

Write latency:
- pend rises one edge after wr_en.
- The new divisor governs the period that starts at the next wrap.
- A write in the same cycle as a wrap is not applied at that wrap. It applies at the following wrap.
- Write to a disabled channel: active one edge later.

Other:
- No combinational path from inputs to outputs.
- Channels are fully independent except for sync.

## Configuration
Macro: CLKDIV_SYNC_EN.
- Defined: sync = 1 forces, on the next edge, every enabled channel to cnt = 0 and clk_out = 0, and applies any pending write (pend <= 0). A write in the same cycle as sync goes to pending. Disabled channels are unaffected beyond their normal hold.
- Undefined: the sync port exists but is ignored, and no sync logic is synthesised.

## Test plan
- Reset, then en = 1 on ch0 with DEFAULT_DIV = 1 in square mode -> clk_out[0] toggles every 2 cycles (period 4); pend = 0 throughout.
- Write ch1 D = 4, pulse mode while disabled, then enable -> one-cycle high on clk_out[1] every 5 cycles; first pulse on the 5th enabled edge.
- ch0 running D = 3, write D = 0 mid-period -> pend[0] = 1 until the next wrap; remaining half-periods stay 4 cycles until then, then 1 cycle; pend clears on the wrap edge.
- Write coincident with a wrap, then a second write of D = 7 before the next wrap -> first write never applied; D = 7 takes effect at the following wrap.
- wr_ch = NUM_CH with wr_en = 1 -> no channel state changes. Assert rst mid-period with a concurrent write -> all outputs 0 and div_act = DEFAULT_DIV next edge.
- With CLKDIV_SYNC_EN: ch0 D = 2 and ch1 D = 5 running, pulse sync -> both clk_out = 0 and aligned. Ch0 next toggles 3 cycles later, ch1 6 cycles later. Without the macro, the same stimulus causes no change.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: square or one-cycle pulse outputs, shadowed divisor/mode writes.
// Optional global phase restart through the sync port when CLKDIV_SYNC_EN is defined.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 1,
  parameter int CH_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_div,
  input  logic              wr_mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend
);

  logic sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_hit    = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt, div_act, div_pend;
    logic             mode_act, mode_pend, pend_q, out_q;
    logic             wr_hit, wrap;

    // Out-of-range channel numbers never match any instance.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));
    assign wrap   = (cnt == div_act);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt       <= '0;
        div_act   <= WIDTH'(DEFAULT_DIV);
        mode_act  <= 1'b0;
        div_pend  <= '0;
        mode_pend <= 1'b0;
        pend_q    <= 1'b0;
        out_q     <= 1'b0;
      end else if (sync_hit && en[i]) begin
        cnt   <= '0;
        out_q <= 1'b0;
        if (pend_q) begin
          div_act  <= div_pend;
          mode_act <= mode_pend;
        end
        pend_q <= 1'b0;
        if (wr_hit) begin
          div_pend  <= wr_div;
          mode_pend <= wr_mode;
          pend_q    <= 1'b1;
        end
      end else if (!en[i]) begin
        cnt   <= '0;
        out_q <= 1'b0;
        if (wr_hit) begin
          div_act  <= wr_div;
          mode_act <= wr_mode;
        end
      end else begin
        if (wrap) begin
          cnt <= '0;
          // A mode switch restarts from low so the new waveform starts clean.
          if (pend_q && (mode_pend != mode_act)) out_q <= 1'b0;
          else if (mode_act)                     out_q <= 1'b1;
          else                                   out_q <= ~out_q;
          if (pend_q) begin
            div_act  <= div_pend;
            mode_act <= mode_pend;
            pend_q   <= 1'b0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
          if (mode_act) out_q <= 1'b0;
        end
        // A write landing on a wrap edge waits for the following wrap.
        if (wr_hit) begin
          div_pend  <= wr_div;
          mode_pend <= wr_mode;
          pend_q    <= 1'b1;
        end
      end
    end

    assign clk_out[i] = out_q;
    assign pend[i]    = pend_q;
  end

endmodule
